midi_parser: RTL

MIDI_PARSER -- requirements
Module: midi_parser

---
 rtl/midi_pkg.sv | 22 ++
 rtl/midi_parser.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: shared constants for the MIDI byte parser.
//   - status high-nibble codes used for channel-message decode
//   - lowest real-time status value (0xF8..0xFF are transparent to parsing)
//   - parser FSM state encoding
package midi_pkg;

    localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
    localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
    localparam logic [3:0] NIB_PROG     = 4'hC;
    localparam logic [3:0] NIB_SYSTEM   = 4'hF;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEY   = 3'd1,
        VEL   = 3'd2,
        PROG  = 3'd3,
        SKIP2 = 3'd4,
        SKIP1 = 3'd5
    } state_e;

endpackage

// File: rtl/midi_parser.sv
// midi_parser: decodes a MIDI byte stream for one channel into synth controls.
//   Parameter CHANNEL   : MIDI channel (0-15) accepted; others are skipped.
//   CLK                 : system clock
//   RST                 : asynchronous active-high reset
//   RX_DATA / RX_VALID  : received byte and its one-cycle strobe
//   NOTE_NUM            : note of the last accepted note-on
//   PROGRAM             : last program-change value (waveform select)
//   VELOCITY            : velocity of the last accepted note-on
//   GATE                : high while the current note is held
//   NOTE_TRIG           : one-cycle pulse per accepted note-on
// Build option: define MIDI_RUNNING_STATUS_EN to keep running status, i.e.
// return to the message's first-data state after each completed message.
import midi_pkg::*;

module midi_parser #(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic [6:0] NOTE_NUM,
    output logic [6:0] PROGRAM,
    output logic [6:0] VELOCITY,
    output logic       GATE,
    output logic       NOTE_TRIG
);

    state_e     state_q,     state_d;
    logic       note_on_q,   note_on_d;
    logic [6:0] key_q,       key_d;
    logic [6:0] note_num_q,  note_num_d;
    logic [6:0] program_q,   program_d;
    logic [6:0] velocity_q,  velocity_d;
    logic       gate_q,      gate_d;
    logic       note_trig_q, note_trig_d;
`ifdef MIDI_RUNNING_STATUS_EN
    // First-data state of the stored running status; IDLE means none.
    state_e     run_q,       run_d;
`endif
    state_e     done_state;

    // Map a non-real-time status byte to the state expecting its first data byte.
    function automatic state_e decode_status(input logic [7:0] b);
        logic [3:0] hi;
        logic [3:0] ch;
        state_e     s;
        hi = b[7:4];
        ch = b[3:0];
        s  = IDLE;
        if (hi == NIB_NOTE_OFF || hi == NIB_NOTE_ON) begin
            s = (ch == CHANNEL) ? KEY : SKIP2;
        end else if (hi == NIB_PROG) begin
            s = (ch == CHANNEL) ? PROG : SKIP1;
        end else if (hi == NIB_SYSTEM) begin
            s = IDLE;
        end else if (hi == 4'hD) begin
            s = SKIP1;
        end else begin
            s = SKIP2;  // 0xA, 0xB, 0xE
        end
        return s;
    endfunction

    always_comb begin
`ifdef MIDI_RUNNING_STATUS_EN
        done_state = run_q;
`else
        done_state = IDLE;
`endif
    end

    always_comb begin
        state_d     = state_q;
        note_on_d   = note_on_q;
        key_d       = key_q;
        note_num_d  = note_num_q;
        program_d   = program_q;
        velocity_d  = velocity_q;
        gate_d      = gate_q;
        note_trig_d = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        run_d       = run_q;
`endif
        // Real-time bytes fall through untouched, even mid-message.
        if (RX_VALID && (RX_DATA < REALTIME_MIN)) begin
            if (RX_DATA[7]) begin
                // Any status aborts a partial message and starts a new one.
                state_d   = decode_status(RX_DATA);
                note_on_d = (RX_DATA[7:4] == NIB_NOTE_ON);
`ifdef MIDI_RUNNING_STATUS_EN
                run_d     = decode_status(RX_DATA);
`endif
            end else begin
                case (state_q)
                    KEY: begin
                        key_d   = RX_DATA[6:0];
                        state_d = VEL;
                    end
                    VEL: begin
                        if (note_on_q && (RX_DATA[6:0] != 7'd0)) begin
                            note_num_d  = key_q;
                            velocity_d  = RX_DATA[6:0];
                            gate_d      = 1'b1;
                            note_trig_d = 1'b1;
                        end else if (key_q == note_num_q) begin
                            gate_d = 1'b0;
                        end
                        state_d = done_state;
                    end
                    PROG: begin
                        program_d = RX_DATA[6:0];
                        state_d   = done_state;
                    end
                    SKIP2:   state_d = SKIP1;
                    SKIP1:   state_d = done_state;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            note_on_q   <= 1'b0;
            key_q       <= '0;
            note_num_q  <= '0;
            program_q   <= '0;
            velocity_q  <= '0;
            gate_q      <= 1'b0;
            note_trig_q <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
            run_q       <= IDLE;
`endif
        end else begin
            state_q     <= state_d;
            note_on_q   <= note_on_d;
            key_q       <= key_d;
            note_num_q  <= note_num_d;
            program_q   <= program_d;
            velocity_q  <= velocity_d;
            gate_q      <= gate_d;
            note_trig_q <= note_trig_d;
`ifdef MIDI_RUNNING_STATUS_EN
            run_q       <= run_d;
`endif
        end
    end

    assign NOTE_NUM  = note_num_q;
    assign PROGRAM   = program_q;
    assign VELOCITY  = velocity_q;
    assign GATE      = gate_q;
    assign NOTE_TRIG = note_trig_q;

endmodule
